// File: rtl/input_flow_pkg.sv
// input_flow_pkg: VC indices, pause FSM encoding and default sizing shared by both ends of the VC FIFO pair
package input_flow_pkg;
  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] PAUSE = 1'b1;
  localparam int DATA_W_D  = 6;
  localparam int VC_BIT_D  = 4;
  localparam int DEPTH_D   = 4;
  localparam int HIGH_TH_D = 3;
  localparam int LOW_TH_D  = 1;
endpackage

// File: rtl/input_flow_vc_occupancy.sv
// vc_occupancy: mirrored FIFO occupancy counter with full/empty decode and hysteretic pause FSM
module vc_occupancy
  import input_flow_pkg::*;
#(
  parameter int DEPTH   = DEPTH_D,
  parameter int HIGH_TH = HIGH_TH_D,
  parameter int LOW_TH  = LOW_TH_D,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_pause
);
  logic [CNT_W-1:0] r_count, w_next;
  logic [0:0]       r_state, w_state;
  // Pops on an empty counter are ignored so the count never wraps below zero
  always_comb begin
    w_next  = r_count + CNT_W'(i_push) - CNT_W'(i_pop && !o_empty);
    w_state = (r_state == RUN && w_next >= CNT_W'(HIGH_TH)) ? PAUSE :
              (r_state == PAUSE && w_next <= CNT_W'(LOW_TH)) ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_state <= RUN;
    end else begin
      r_count <= w_next;
      r_state <= w_state;
    end
  end
  assign o_count = r_count;
  assign o_full  = r_count == CNT_W'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_pause = r_state == PAUSE;
endmodule

// File: rtl/input_flow.sv
// input_flow: ingress VC steering, occupancy mirroring, pause and drop control for the VC FIFO pair
// Optional saturating per-VC drop counters under INPUT_FLOW_DROP_CNT_EN
module input_flow
  import input_flow_pkg::*;
#(
  parameter int DATA_W  = DATA_W_D,
  parameter int VC_BIT  = VC_BIT_D,
  parameter int DEPTH   = DEPTH_D,
  parameter int HIGH_TH = HIGH_TH_D,
  parameter int LOW_TH  = LOW_TH_D,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop_vc0,
  input  logic              pop_vc1,
  output logic              push_vc0,
  output logic              push_vc1,
  output logic [DATA_W-1:0] data_out,
  output logic              pause_vc0,
  output logic              pause_vc1,
  output logic              full_vc0,
  output logic              full_vc1,
  output logic              empty_vc0,
  output logic              empty_vc1,
  output logic [CNT_W-1:0]  count_vc0,
  output logic [CNT_W-1:0]  count_vc1,
  output logic              drop_pulse,
  output logic              err_underflow
`ifdef INPUT_FLOW_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt_vc0,
  output logic [7:0]        drop_cnt_vc1
`endif
);
  logic w_vc, w_acc0, w_acc1, w_drop0, w_drop1;
  logic r_push0, r_push1, r_drop, r_uf;
  logic [DATA_W-1:0] r_data;
  // Drop decision uses the pre-edge full flag; a same-edge pop does not rescue the word
  always_comb begin
    w_vc    = data_in[VC_BIT];
    w_acc0  = valid_in && w_vc == VC0 && !full_vc0;
    w_acc1  = valid_in && w_vc == VC1 && !full_vc1;
    w_drop0 = valid_in && w_vc == VC0 && full_vc0;
    w_drop1 = valid_in && w_vc == VC1 && full_vc1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push0 <= 1'b0;
      r_push1 <= 1'b0;
      r_drop  <= 1'b0;
      r_uf    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_push0 <= w_acc0;
      r_push1 <= w_acc1;
      r_drop  <= w_drop0 || w_drop1;
      r_uf    <= (pop_vc0 && empty_vc0) || (pop_vc1 && empty_vc1);
      if (w_acc0 || w_acc1) r_data <= data_in;
    end
  end
  vc_occupancy #(.DEPTH(DEPTH), .HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH)) u_vc0 (
    .clk(clk), .reset(reset), .i_push(w_acc0), .i_pop(pop_vc0),
    .o_count(count_vc0), .o_full(full_vc0), .o_empty(empty_vc0), .o_pause(pause_vc0)
  );
  vc_occupancy #(.DEPTH(DEPTH), .HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH)) u_vc1 (
    .clk(clk), .reset(reset), .i_push(w_acc1), .i_pop(pop_vc1),
    .o_count(count_vc1), .o_full(full_vc1), .o_empty(empty_vc1), .o_pause(pause_vc1)
  );
  assign push_vc0      = r_push0;
  assign push_vc1      = r_push1;
  assign data_out      = r_data;
  assign drop_pulse    = r_drop;
  assign err_underflow = r_uf;
`ifdef INPUT_FLOW_DROP_CNT_EN
  logic [7:0] r_dc0, r_dc1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dc0 <= '0;
      r_dc1 <= '0;
    end else begin
      if (w_drop0 && r_dc0 != 8'hFF) r_dc0 <= r_dc0 + 8'd1;
      if (w_drop1 && r_dc1 != 8'hFF) r_dc1 <= r_dc1 + 8'd1;
    end
  end
  assign drop_cnt_vc0 = r_dc0;
  assign drop_cnt_vc1 = r_dc1;
`endif
endmodule

// File: tb/tb_input_flow.sv
// tb_input_flow: directed and random stimulus against a reference model with a push scoreboard
module tb_input_flow;
  import input_flow_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1, valid_in = 1'b0, pop_vc0 = 1'b0, pop_vc1 = 1'b0;
  logic [5:0] data_in = '0;
  logic push_vc0, push_vc1, pause_vc0, pause_vc1, full_vc0, full_vc1, empty_vc0, empty_vc1;
  logic drop_pulse, err_underflow;
  logic [5:0] data_out;
  logic [2:0] count_vc0, count_vc1;
`ifdef INPUT_FLOW_DROP_CNT_EN
  logic [7:0] drop_cnt_vc0, drop_cnt_vc1;
`endif
  int tests = 0, fails = 0;
  logic [6:0] q[$];
  int m0, m1;
  logic mp0, mp1, e_drop, e_uf;
  logic [5:0] md;
  logic [7:0] mdc0, mdc1;

  input_flow dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_vc0(push_vc0), .push_vc1(push_vc1),
    .data_out(data_out), .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
    .full_vc0(full_vc0), .full_vc1(full_vc1), .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .count_vc0(count_vc0), .count_vc1(count_vc1), .drop_pulse(drop_pulse),
    .err_underflow(err_underflow)
`ifdef INPUT_FLOW_DROP_CNT_EN
    , .drop_cnt_vc0(drop_cnt_vc0), .drop_cnt_vc1(drop_cnt_vc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [5:0] d, input logic p0, input logic p1);
    logic vc, acc;
    int n0, n1;
    logic [6:0] ent;
    @(negedge clk);
    reset = r; valid_in = v; data_in = d; pop_vc0 = p0; pop_vc1 = p1;
    vc = d[VC_BIT_D];
    if (r) begin
      m0 = 0; m1 = 0; mp0 = 0; mp1 = 0; md = '0; mdc0 = '0; mdc1 = '0;
      e_drop = 0; e_uf = 0; q.delete();
    end else begin
      acc = v && ((vc ? m1 : m0) < DEPTH_D);
      e_drop = v && !acc;
      e_uf = (p0 && m0 == 0) || (p1 && m1 == 0);
      if (acc) begin
        q.push_back({vc, d});
        md = d;
      end
      n0 = m0 + ((acc && !vc) ? 1 : 0) - ((p0 && m0 > 0) ? 1 : 0);
      n1 = m1 + ((acc && vc) ? 1 : 0) - ((p1 && m1 > 0) ? 1 : 0);
      mp0 = (n0 >= HIGH_TH_D) ? 1'b1 : (n0 <= LOW_TH_D) ? 1'b0 : mp0;
      mp1 = (n1 >= HIGH_TH_D) ? 1'b1 : (n1 <= LOW_TH_D) ? 1'b0 : mp1;
      m0 = n0; m1 = n1;
      if (e_drop && !vc && mdc0 != 8'hFF) mdc0++;
      if (e_drop && vc && mdc1 != 8'hFF) mdc1++;
    end
    @(posedge clk);
    #1;
    if (push_vc0 || push_vc1) begin
      if (q.size() == 0) chk("sb_spurious", {30'd0, push_vc1, push_vc0}, 0);
      else begin
        ent = q.pop_front();
        chk("sb_vc", {30'd0, push_vc1, push_vc0}, ent[6] ? 2 : 1);
        chk("sb_data", {26'd0, data_out}, {26'd0, ent[5:0]});
      end
    end
    chk("sb_pending", q.size(), 0);
    chk("data_hold", {26'd0, data_out}, {26'd0, md});
    chk("count0", {29'd0, count_vc0}, m0);
    chk("count1", {29'd0, count_vc1}, m1);
    chk("pause0", {31'd0, pause_vc0}, {31'd0, mp0});
    chk("pause1", {31'd0, pause_vc1}, {31'd0, mp1});
    chk("full0", {31'd0, full_vc0}, (m0 == DEPTH_D) ? 1 : 0);
    chk("full1", {31'd0, full_vc1}, (m1 == DEPTH_D) ? 1 : 0);
    chk("empty0", {31'd0, empty_vc0}, (m0 == 0) ? 1 : 0);
    chk("empty1", {31'd0, empty_vc1}, (m1 == 0) ? 1 : 0);
    chk("drop", {31'd0, drop_pulse}, {31'd0, e_drop});
    chk("underflow", {31'd0, err_underflow}, {31'd0, e_uf});
`ifdef INPUT_FLOW_DROP_CNT_EN
    chk("dropcnt0", {24'd0, drop_cnt_vc0}, {24'd0, mdc0});
    chk("dropcnt1", {24'd0, drop_cnt_vc1}, {24'd0, mdc1});
`endif
  endtask

  initial begin
    step(1, 1, 6'h1F, 0, 0);
    step(1, 1, 6'h1F, 0, 0);
    chk("rst_push", {30'd0, push_vc1, push_vc0}, 0);
    chk("rst_empty", {30'd0, empty_vc1, empty_vc0}, 3);
    step(0, 1, 6'h10, 0, 0);
    step(0, 1, 6'h12, 0, 0);
    step(0, 1, 6'h14, 0, 0);
    chk("vc1_cnt3", {29'd0, count_vc1}, 3);
    chk("vc1_pause", {31'd0, pause_vc1}, 1);
    chk("vc1_push3", {31'd0, push_vc1}, 1);
    for (int i = 1; i <= 4; i++) step(0, 1, 6'(i), 0, 0);
    step(0, 1, 6'h05, 0, 0);
    chk("vc0_drop", {31'd0, drop_pulse}, 1);
    chk("vc0_nopush", {31'd0, push_vc0}, 0);
    chk("vc0_full", {31'd0, full_vc0}, 1);
    chk("vc0_cnt4", {29'd0, count_vc0}, 4);
    step(0, 1, 6'h06, 1, 0);
    chk("drop_vs_pop", {31'd0, drop_pulse}, 1);
    step(0, 0, 6'h00, 0, 1);
    chk("pop1_held", {31'd0, pause_vc1}, 1);
    step(0, 0, 6'h00, 0, 1);
    chk("pop1_clear", {31'd0, pause_vc1}, 0);
    step(0, 0, 6'h00, 1, 0);
    step(0, 1, 6'h07, 1, 0);
    chk("pushpop_cnt", {29'd0, count_vc0}, 2);
    step(0, 0, 6'h00, 0, 1);
    step(0, 0, 6'h00, 0, 1);
    chk("uf_pulse", {31'd0, err_underflow}, 1);
    chk("uf_cnt", {29'd0, count_vc1}, 0);
    step(0, 0, 6'h00, 0, 0);
    for (int i = 0; i < 80; i++)
      step(0, 1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    step(0, 1, 6'h11, 0, 0);
    step(1, 1, 6'h12, 1, 1);
    chk("midrst_push", {30'd0, push_vc1, push_vc0}, 0);
    step(0, 0, 6'h00, 0, 0);
`ifdef INPUT_FLOW_DROP_CNT_EN
    for (int i = 0; i < 4; i++) step(0, 1, 6'h01, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 6'h02, 0, 0);
    chk("dc0_sat", {24'd0, drop_cnt_vc0}, 255);
    chk("dc1_zero", {24'd0, drop_cnt_vc1}, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/input_flow.md
Name: input_flow

Overview:
Ingress-side flow controller, the write end of the VC FIFO pair drained by the output pop/arbitration logic.
- Steers each incoming word into VC0 or VC1 by a class bit.
- Mirrors each FIFO's occupancy from its own pushes and the downstream pops.
- Raises per-VC pause to upstream with hysteresis thresholds, and drops words aimed at a full VC.

Parameters:
DATA_W, 6, width of data word
VC_BIT, 4, bit index of data_in selecting VC (0 -> VC0, 1 -> VC1)
DEPTH, 4, entries per VC FIFO
HIGH_TH, 3, occupancy at/above which pause asserts
LOW_TH, 1, occupancy at/below which pause deasserts (must satisfy LOW_TH < HIGH_TH <= DEPTH)
CNT_W, localparam = $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
valid_in  in  1  data_in valid this cycle
data_in  in  DATA_W  incoming word
pop_vc0  in  1  downstream popped VC0 this cycle
pop_vc1  in  1  downstream popped VC1 this cycle
push_vc0  out  1  registered write strobe to VC0 FIFO
push_vc1  out  1  registered write strobe to VC1 FIFO
data_out  out  DATA_W  registered word, shared by both FIFOs
pause_vc0  out  1  VC0 almost-full, hysteretic
pause_vc1  out  1  VC1 almost-full, hysteretic
full_vc0, full_vc1  out  1 each  count == DEPTH
empty_vc0, empty_vc1  out  1 each  count == 0
count_vc0, count_vc1  out  CNT_W each  mirrored occupancy
drop_pulse  out  1  one-cycle pulse: word dropped
err_underflow  out  1  one-cycle pulse: pop seen on empty VC

Behaviour:
- Reset (synchronous, active-high):
  - push_*, data_out, pause_*, count_*, drop_pulse, err_underflow all go to 0.
  - empty_* = 1, full_* = 0.
  - Reset asserted mid-traffic discards any pending push and clears counts on that edge.
- Accept: at a clk edge with valid_in = 1, the target VC is v = data_in[VC_BIT].
  - If count_v < DEPTH: set push_vv = 1 and data_out = data_in for exactly the next cycle (1-cycle latency). The count increments on that same edge.
  - If count_v == DEPTH: no push, drop_pulse = 1 next cycle, count unchanged.
  - A decrement on the same edge does not rescue the word; the drop decision uses the pre-edge count.
- data_out holds its last value when no push is issued.
- Pops: pop_vcX sampled at an edge decrements count_vcX.
  - Push and pop to the same VC on the same edge: count unchanged.
  - Pop with count 0: ignored, count stays 0, err_underflow pulses next cycle.
- Per-VC pause FSM, states RUN and PAUSE, evaluated on the next-count value:
  - RUN -> PAUSE when next_count >= HIGH_TH.
  - PAUSE -> RUN when next_count <= LOW_TH.
  - Otherwise hold. pause output = (state == PAUSE), registered.
- full/empty are combinational decodes of registered counts.
- At most one push strobe is high per cycle.
- Counters never wrap: saturate at DEPTH (via the drop path) and at 0 (via the underflow path).

Optional Feature:
INPUT_FLOW_DROP_CNT_EN
- Defined: adds outputs drop_cnt_vc0 and drop_cnt_vc1, 8 bits each.
  - Each increments on a drop to its VC and saturates at 255.
  - Reset to 0; cleared only by reset.
- Undefined: ports and counters are absent; drop_pulse is unchanged.

Decomposition:
- Shared package: VC index constants (VC0 = 0, VC1 = 1), pause FSM state encoding (RUN = 0, PAUSE = 1), and the default DATA_W/DEPTH/threshold constants, shared with the output side.
- One natural sub-module, vc_occupancy: counter + full/empty + pause FSM, instantiated twice.

Test Plan:
- Reset with valid_in = 1, data_in = 6'h1F -> no push, counts 0, empty_* = 1, pause_* = 0.
- Three VC1 words (data_in = 6'h10, 6'h12, 6'h14), no pops -> push_vc1 one cycle after each, count_vc1 = 3, pause_vc1 = 1 with the third push.
- VC0 filled to 4, then fifth word 6'h05 -> no push_vc0, drop_pulse one cycle, count_vc0 stays 4, full_vc0 = 1.
- count_vc1 = 3 with paused: pop_vc1 twice -> count 2 (pause held), then 1 (pause clears same edge).
- Simultaneous VC0 push and pop_vc0 at count 2 -> count stays 2. pop_vc1 at count 0 -> err_underflow pulse, count 0.
- With INPUT_FLOW_DROP_CNT_EN: 300 drops to VC0 -> drop_cnt_vc0 = 255, drop_cnt_vc1 = 0.
